// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg -- shared types and constants for the UART frame scheduler.
//   state_e        : scheduler FSM states (StSendCk present only with UART_SCHED_CKSUM_EN)
//   SofByteDefault : default start-of-frame byte
//   IdPrefix/IdIdxW: ID byte format, {zero prefix, requester index}
// Build option: UART_SCHED_CKSUM_EN adds the checksum state.
package uart_sched_pkg;

  localparam logic [7:0] SofByteDefault = 8'hA5;

  // ID byte = zero prefix concatenated with a 3-bit requester index.
  localparam int unsigned IdIdxW = 3;
  localparam logic [7-IdIdxW:0] IdPrefix = '0;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StSendSof,
    StSendId,
    StSendPay,
`ifdef UART_SCHED_CKSUM_EN
    StSendCk,
`endif
    StGuard
  } state_e;

  function automatic logic [7:0] id_byte(input logic [IdIdxW-1:0] idx);
    return {IdPrefix, idx};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- purely combinational round-robin arbiter.
//   req   : request vector
//   ptr   : highest-priority index for this decision
//   grant : one-hot winner, first asserted req at or after ptr (wrapping); zero if no req
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler -- arbitrates NUM_REQ byte sources and serialises one frame at a time
// to a UART transmitter: SOF_BYTE, ID byte, payload, optional XOR checksum.
// Build option: define UART_SCHED_CKSUM_EN to append the checksum byte.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req                   : per-requester frame request (level)
//   grant                 : one-hot owner of the current frame, zero when idle
//   src_data/valid/last   : per-requester payload byte stream
//   src_ready             : byte-accept pulse to the granted requester
//   tx_data, tx_start     : byte and load pulse to the UART transmitter
//   tx_busy               : UART transmitter busy
//   frame_done, err_trunc : end-of-frame pulse, MAX_LEN truncation pulse
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_LEN  = 16,
  parameter logic [7:0]  SOF_BYTE = SofByteDefault
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  input  logic [8*NUM_REQ-1:0] src_data,
  input  logic [NUM_REQ-1:0]   src_valid,
  input  logic [NUM_REQ-1:0]   src_last,
  output logic [NUM_REQ-1:0]   src_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 frame_done,
  output logic                 err_trunc
);

  localparam int unsigned      PtrW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]       MaxLen8 = 8'(MAX_LEN);
  localparam logic [IdIdxW-1:0] LastIdx = IdIdxW'(NUM_REQ - 1);

  // Where the frame goes after its final payload byte.
`ifdef UART_SCHED_CKSUM_EN
  localparam state_e StPayEnd = StSendCk;
`else
  localparam state_e StPayEnd = StIdle;
`endif

  state_e              r_state, w_state_d;
  state_e              r_ret, w_ret_d;      // state to resume after GUARD
  logic [NUM_REQ-1:0]  r_grant, w_grant_d;
  logic [IdIdxW-1:0]   r_gidx, w_gidx_d;
  logic [PtrW-1:0]     r_ptr, w_ptr_d;
  logic [7:0]          r_cnt, w_cnt_d;
  logic                r_trunc, w_trunc_d;
`ifdef UART_SCHED_CKSUM_EN
  logic [7:0]          r_cksum, w_cksum_d;
`endif

  logic [NUM_REQ-1:0]  w_arb_grant;
  logic [IdIdxW-1:0]   w_arb_idx;
  logic [7:0]          w_src_data;
  logic                w_src_valid;
  logic                w_src_last;
  logic [7:0]          w_cnt_inc;
  logic [PtrW-1:0]     w_ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PtrW)
  ) u_rr_arbiter (
    .req   (req),
    .ptr   (r_ptr),
    .grant (w_arb_grant)
  );

  always_comb begin
    w_arb_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_arb_grant[i]) w_arb_idx = IdIdxW'(i);
    end
  end

  // Payload stream of the current owner.
  always_comb begin
    w_src_data  = '0;
    w_src_valid = 1'b0;
    w_src_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_gidx == IdIdxW'(i)) begin
        w_src_data  = src_data[8*i +: 8];
        w_src_valid = src_valid[i];
        w_src_last  = src_last[i];
      end
    end
  end

  assign w_cnt_inc  = r_cnt + 8'd1;
  assign w_ptr_next = (r_gidx == LastIdx) ? '0 : PtrW'({1'b0, r_gidx} + 4'd1);
  assign grant      = r_grant;

  always_comb begin
    w_state_d  = r_state;
    w_ret_d    = r_ret;
    w_grant_d  = r_grant;
    w_gidx_d   = r_gidx;
    w_ptr_d    = r_ptr;
    w_cnt_d    = r_cnt;
    w_trunc_d  = r_trunc;
`ifdef UART_SCHED_CKSUM_EN
    w_cksum_d  = r_cksum;
`endif
    tx_start   = 1'b0;
    tx_data    = 8'h00;
    src_ready  = '0;
    frame_done = 1'b0;
    err_trunc  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (|req) w_state_d = StArb;
      end
      StArb: begin
        if (|req) begin
          w_grant_d = w_arb_grant;
          w_gidx_d  = w_arb_idx;
          w_state_d = StSendSof;
        end else begin
          w_state_d = StIdle;
        end
      end
      StSendSof: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          tx_data   = SOF_BYTE;
          w_ret_d   = StSendId;
          w_state_d = StGuard;
        end
      end
      StSendId: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          tx_data   = id_byte(r_gidx);
`ifdef UART_SCHED_CKSUM_EN
          w_cksum_d = id_byte(r_gidx);
`endif
          w_ret_d   = StSendPay;
          w_state_d = StGuard;
        end
      end
      StSendPay: begin
        if (!tx_busy && w_src_valid) begin
          tx_start  = 1'b1;
          tx_data   = w_src_data;
          src_ready = r_grant;
          w_cnt_d   = w_cnt_inc;
`ifdef UART_SCHED_CKSUM_EN
          w_cksum_d = r_cksum ^ w_src_data;
`endif
          w_state_d = StGuard;
          if (w_src_last) begin
            w_ret_d = StPayEnd;
          end else if (w_cnt_inc == MaxLen8) begin
            // Cut here; the rest of the source stream stays unconsumed.
            w_ret_d   = StPayEnd;
            w_trunc_d = 1'b1;
          end else begin
            w_ret_d = StSendPay;
          end
        end
      end
`ifdef UART_SCHED_CKSUM_EN
      StSendCk: begin
        if (!tx_busy) begin
          tx_start  = 1'b1;
          tx_data   = r_cksum;
          w_ret_d   = StIdle;
          w_state_d = StGuard;
        end
      end
`endif
      StGuard: begin
        // Covers the one-cycle tx_busy rise latency after every tx_start.
        w_state_d = r_ret;
        if (r_ret == StIdle) begin
          frame_done = 1'b1;
          err_trunc  = r_trunc;
          w_grant_d  = '0;
          w_ptr_d    = w_ptr_next;
          w_cnt_d    = '0;
          w_trunc_d  = 1'b0;
`ifdef UART_SCHED_CKSUM_EN
          w_cksum_d  = '0;
`endif
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_ret   <= StIdle;
    end else begin
      r_state <= w_state_d;
      r_ret   <= w_ret_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
`ifdef UART_SCHED_CKSUM_EN
      r_cksum <= '0;
`endif
    end else begin
      r_grant <= w_grant_d;
      r_gidx  <= w_gidx_d;
      r_ptr   <= w_ptr_d;
      r_cnt   <= w_cnt_d;
      r_trunc <= w_trunc_d;
`ifdef UART_SCHED_CKSUM_EN
      r_cksum <= w_cksum_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter MAX_LEN, default 16, maximum payload bytes per frame (1..255).
REQ-003 Parameter SOF_BYTE, default 8'hA5, start-of-frame byte.
REQ-004 Port clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Port req  in  NUM_REQ  per-requester frame request, level.
REQ-007 Port grant  out  NUM_REQ  one-hot owner of current frame, zero when idle.
REQ-008 Port src_data  in  8*NUM_REQ  payload byte per requester, slice i = bits 8i+7:8i.
REQ-009 Port src_valid  in  NUM_REQ  payload byte valid per requester.
REQ-010 Port src_last  in  NUM_REQ  marks final payload byte, qualified by src_valid.
REQ-011 Port src_ready  out  NUM_REQ  one-cycle byte-accept pulse, only to the granted requester.
REQ-012 Port tx_data  out  8  byte to the UART transmitter.
REQ-013 Port tx_start  out  1  one-cycle load pulse to the UART transmitter.
REQ-014 Port tx_busy  in  1  UART transmitter busy, high from the cycle after tx_start to end of stop bit.
REQ-015 Port frame_done  out  1  one-cycle pulse after the final byte of a frame is accepted by the UART.
REQ-016 Port err_trunc  out  1  one-cycle pulse when a frame is cut at MAX_LEN.

Function
REQ-017 Frame SHALL be: SOF_BYTE, ID byte (8'h0 concatenated with the grant index), payload bytes, optional checksum (REQ-034).
REQ-018 FSM states SHALL be IDLE, ARB, SEND_SOF, SEND_ID, SEND_PAY, SEND_CK, GUARD.
REQ-019 IDLE->ARB when any req bit is high; ARB SHALL pick one requester round-robin, starting from rr_ptr, in one cycle, and latch grant.
REQ-020 rr_ptr SHALL become (winner+1) mod NUM_REQ when the frame completes; with a single active requester, it SHALL win back-to-back.
REQ-021 A byte is issued only when tx_busy=0 and not in GUARD; tx_start SHALL be high for exactly that cycle, with tx_data valid in the same cycle.
REQ-022 GUARD SHALL last exactly one cycle after every tx_start, to cover the tx_busy rise latency, then return to the next send state.
REQ-023 SEND_PAY: tx_start=src_ready[g]=1 in the same cycle only if src_valid[g]=1 and tx_busy=0; if src_valid[g]=0, wait indefinitely with no byte sent.
REQ-024 Payload byte counter SHALL be 8 bits and count accepted bytes; src_last leads to SEND_CK (if enabled) or frame end.
REQ-025 If MAX_LEN bytes are accepted without src_last, the frame SHALL end as if last, and err_trunc SHALL pulse with frame_done.
REQ-026 After a frame is cut at MAX_LEN, remaining source bytes SHALL NOT be consumed; they form the next frame when granted.
REQ-027 frame_done SHALL pulse once, in the cycle after the last tx_start; the FSM SHALL then go to IDLE, and grant SHALL clear in the same cycle.
REQ-028 Dropping req mid-frame SHALL NOT abort the frame; only src_last, MAX_LEN or reset ends it.
REQ-029 Requests arriving during a frame SHALL wait; no preemption.
REQ-030 Minimum frame latency, req to first tx_start with tx_busy=0: 2 cycles (IDLE->ARB->SEND_SOF).

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, grant=0, src_ready=0, tx_start=0, tx_data=8'h00, frame_done=0, err_trunc=0, rr_ptr=0, byte counter=0, checksum=0.
REQ-032 Reset mid-frame SHALL abandon the frame with no further tx_start; the UART transmitter finishes any byte it holds on its own.
REQ-033 Release of rst_n SHALL take effect on the next clk edge; req already high SHALL be arbitrated from index 0.

Configuration
REQ-034 With UART_SCHED_CKSUM_EN defined, SEND_CK SHALL transmit the XOR of the ID byte and all payload bytes sent, after the last payload byte.
REQ-035 Without UART_SCHED_CKSUM_EN, SEND_CK and the checksum register SHALL not exist, and the frame SHALL end after the last payload byte.

Structure
REQ-036 A package uart_sched_pkg SHALL hold the state enum, the SOF_BYTE default and the ID byte format constants.
REQ-037 Round-robin arbitration SHALL be one sub-module rr_arbiter (inputs: req, ptr; output: one-hot grant) and SHALL be purely combinational.

Verification
REQ-038 The bench SHALL cover these scenarios:
- req=4'b0001, 2 bytes 8'h11,8'h22 with last -> A5,00,11,22,(CK=33) on tx_data; one frame_done.
- req=4'b1010 held, 1 byte each -> frames ordered ID 01 then 03, then 01 again.
- src_valid[g] low 10 cycles mid-payload -> no tx_start, no src_ready during the gap; frame then completes.
- MAX_LEN=4, source supplies 6 bytes -> first frame 4 payload bytes with err_trunc; next frame 2 bytes.
- rst_n low during SEND_PAY -> all outputs 0 that cycle; after release, req=4'b0100 wins with ID 02.
- tx_busy held high 100 cycles -> tx_start never asserts until it drops; exactly one tx_start per byte.
